// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared types for the LFSR stream generator.
//   lfsr_mode_e  : feedback structure (Fibonacci or Galois)
//   lfsr_state_e : control FSM states
// -----------------------------------------------------------------------------
package lfsr_pkg;

    typedef enum logic {
        LFSR_FIB,
        LFSR_GAL
    } lfsr_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } lfsr_state_e;

endpackage : lfsr_pkg

// File: rtl/lfsr_stream_gen_if.sv
// -----------------------------------------------------------------------------
// lfsr_stream_gen_if
// Control and stream signals of the LFSR stream generator.
// Signal suffixes are relative to the generator.
//   LOAD_I/POLY_I/SEED_I/MODE_I : configuration capture
//   LEN_I/START_I               : run request
//   DATA_O/VALID_O/READY_I      : output stream handshake
//   BUSY_O/DONE_O/LOCK_O        : status
// slave  : the generator side
// master : the controller / consumer side
// -----------------------------------------------------------------------------
interface lfsr_stream_gen_if #(
    parameter int W     = 8,
    parameter int CNT_W = 16
);

    logic             LOAD_I;
    logic [W-1:0]     POLY_I;
    logic [W-1:0]     SEED_I;
    logic             MODE_I;
    logic [CNT_W-1:0] LEN_I;
    logic             START_I;
    logic [W-1:0]     DATA_O;
    logic             VALID_O;
    logic             READY_I;
    logic             BUSY_O;
    logic             DONE_O;
    logic             LOCK_O;

    modport slave (
        input  LOAD_I, POLY_I, SEED_I, MODE_I, LEN_I, START_I, READY_I,
        output DATA_O, VALID_O, BUSY_O, DONE_O, LOCK_O
    );

    modport master (
        output LOAD_I, POLY_I, SEED_I, MODE_I, LEN_I, START_I, READY_I,
        input  DATA_O, VALID_O, BUSY_O, DONE_O, LOCK_O
    );

endinterface : lfsr_stream_gen_if

// File: rtl/lfsr_next_state.sv
// -----------------------------------------------------------------------------
// lfsr_next_state
// Purely combinational single-step LFSR update.
//   state : current LFSR state
//   poly  : tap mask, bit i = tap on state bit i
//   mode  : LFSR_FIB shifts left and feeds the tap parity into bit 0;
//           LFSR_GAL shifts right and XORs the mask in when bit 0 is set
//   next  : state after one step
// -----------------------------------------------------------------------------
module lfsr_next_state
    import lfsr_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] state,
    input  logic [W-1:0] poly,
    input  lfsr_mode_e   mode,
    output logic [W-1:0] next
);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block can leave it unassigned and infer a latch.
        next = state;
        if (mode == LFSR_GAL) begin
            next = {1'b0, state[W-1:1]} ^ ({W{state[0]}} & poly);
        end else begin
            next = {state[W-2:0], ^(state & poly)};
        end
    end

endmodule : lfsr_next_state

// File: rtl/lfsr_stream_gen.sv
// -----------------------------------------------------------------------------
// lfsr_stream_gen
// Programmable Fibonacci/Galois LFSR whose successive states are streamed out
// over a valid/ready handshake for a programmable number of beats.
//   CLK_I   : clock, rising edge
//   RST_I   : asynchronous active-high reset
//   bus     : lfsr_stream_gen_if.slave
//             LOAD_I captures POLY_I/SEED_I/MODE_I (IDLE only, wins over START_I)
//             START_I + LEN_I begin a run (IDLE only)
//             DATA_O/VALID_O/READY_I stream the states, first beat = current state
//             BUSY_O high outside IDLE, DONE_O one-cycle pulse after last beat,
//             LOCK_O sticky flag for a START attempted on the all-zero state
// The final state is kept after a run so a later START continues the sequence.
// -----------------------------------------------------------------------------
module lfsr_stream_gen
    import lfsr_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    lfsr_stream_gen_if.slave  bus
);

    lfsr_state_e      fsm_q;
    lfsr_state_e      fsm_d;
    logic [W-1:0]     state_q;
    logic [W-1:0]     poly_q;
    lfsr_mode_e       mode_q;
    logic [CNT_W-1:0] cnt_q;
    logic             lock_q;
    logic [W-1:0]     state_next;

    logic             in_idle;
    logic             load_ok;
    logic             start_ok;
    logic             state_zero;
    logic             beat_fire;
    logic             last_beat;

    lfsr_next_state #(
        .W (W)
    ) u_next (
        .state (state_q),
        .poly  (poly_q),
        .mode  (mode_q),
        .next  (state_next)
    );

    assign in_idle    = (fsm_q == ST_IDLE);
    assign load_ok    = in_idle && bus.LOAD_I;
    // LOAD takes priority over a simultaneous START.
    assign start_ok   = in_idle && bus.START_I && !bus.LOAD_I;
    assign state_zero = (state_q == '0);
    assign beat_fire  = (fsm_q == ST_RUN) && bus.READY_I;
    assign last_beat  = (cnt_q == CNT_W'(1));

    // Next-state logic of the control FSM.
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            ST_IDLE: begin
                // A START on the all-zero state would stream zeros forever;
                // it is refused here and flagged through LOCK_O instead.
                if (start_ok && !state_zero) begin
                    fsm_d = (bus.LEN_I == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (beat_fire && last_beat) begin
                    fsm_d = ST_DONE;
                end
            end
            ST_DONE: begin
                fsm_d = ST_IDLE;
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: the reset is in the sensitivity list, so it clears the registers
    // (and hence the outputs) immediately rather than at the next clock edge.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            fsm_q <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            fsm_q <= fsm_d;
        end
    end

    // Datapath registers: LFSR state, configuration, beat counter, lock flag.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q <= '0;
            poly_q  <= '0;
            mode_q  <= LFSR_FIB;
            cnt_q   <= '0;
            lock_q  <= 1'b0;
        end else begin
            if (load_ok) begin
                poly_q  <= bus.POLY_I;
                state_q <= bus.SEED_I;
                mode_q  <= lfsr_mode_e'(bus.MODE_I);
                lock_q  <= 1'b0;
            end else if (start_ok) begin
                if (state_zero) begin
                    lock_q <= 1'b1;
                end else begin
                    cnt_q  <= bus.LEN_I;
                end
            end

            // Only reachable in RUN, where the IDLE-only branches above are
            // inactive, so the two never compete for state_q.
            if (beat_fire) begin
                state_q <= state_next;
                cnt_q   <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign bus.DATA_O  = state_q;
    assign bus.VALID_O = (fsm_q == ST_RUN);
    assign bus.BUSY_O  = !in_idle;
    assign bus.DONE_O  = (fsm_q == ST_DONE);
    assign bus.LOCK_O  = lock_q;

endmodule : lfsr_stream_gen

// File: tb/tb_lfsr_stream_gen.sv
// -----------------------------------------------------------------------------
// tb_lfsr_stream_gen
// Scoreboard bench for lfsr_stream_gen at W=4. Stimulus pushes the expected
// beats into a queue; an independent monitor pops and compares on every
// handshake, checks stall stability and counts DONE pulses.
// -----------------------------------------------------------------------------
module tb_lfsr_stream_gen;

    localparam int W     = 4;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    lfsr_stream_gen_if #(.W(W), .CNT_W(CNT_W)) bus ();

    lfsr_stream_gen #(
        .W     (W),
        .CNT_W (CNT_W)
    ) dut (
        .CLK_I (clk),
        .RST_I (rst),
        .bus   (bus.slave)
    );

    int tests     = 0;
    int fails     = 0;
    int done_seen = 0;
    int exp_done  = 0;
    int beats_seen = 0;
    bit ready_rand = 1'b0;

    logic [W-1:0] exp_q [$];

    // Reference sequences for POLY=1100, SEED=0001.
    logic [W-1:0] fib_seq [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                                   4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
    logic [W-1:0] gal_seq [15] = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE,
                                   4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2};

    // Behavioural model of the generator's architectural state.
    int unsigned m_state = 0;
    int unsigned m_poly  = 0;
    bit          m_mode  = 1'b0;
    bit          m_lock  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One LFSR step written as plain arithmetic on integers.
    function automatic int unsigned ref_next(input int unsigned s);
        int unsigned mask;
        int unsigned parity;
        mask   = (32'd1 << W) - 32'd1;
        parity = 32'($countones(s & m_poly)) & 32'd1;
        if (!m_mode) return ((s * 2) + parity) & mask;
        return (s / 2) ^ (((s % 2) == 1) ? m_poly : 32'd0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int unsigned poly, input int unsigned seed, input bit mode);
        bus.LOAD_I = 1'b1;
        bus.POLY_I = W'(poly);
        bus.SEED_I = W'(seed);
        bus.MODE_I = mode;
        tick();
        bus.LOAD_I = 1'b0;
        m_poly  = poly;
        m_state = seed;
        m_mode  = mode;
        m_lock  = 1'b0;
    endtask

    // Issues a START and updates the model; pushes model beats if asked.
    task automatic start_run(input int len, input bit push_model);
        if (m_state == 0) begin
            m_lock = 1'b1;
        end else begin
            exp_done++;
            for (int i = 0; i < len; i++) begin
                if (push_model) exp_q.push_back(W'(m_state));
                m_state = ref_next(m_state);
            end
        end
        bus.LEN_I   = CNT_W'(len);
        bus.START_I = 1'b1;
        tick();
        bus.START_I = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.BUSY_O && n < 500);
        check({name, "_idle"},    bus.BUSY_O, 0);
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_dones"},   done_seen, exp_done);
        check({name, "_lock"},    bus.LOCK_O, m_lock);
        check({name, "_state"},   bus.DATA_O, m_state);
        tick();
    endtask

    // READY driver.
    initial begin
        bus.READY_I = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.READY_I = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: scoreboard pop on handshake, stall stability, DONE pulse width.
    initial begin
        logic [W-1:0] held;
        logic [W-1:0] exp;
        bit stalled;
        bit prev_done;
        stalled   = 1'b0;
        prev_done = 1'b0;
        held      = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled   = 1'b0;
                prev_done = 1'b0;
                continue;
            end
            if (stalled) check("stall_stable", {bus.VALID_O, bus.DATA_O}, {1'b1, held});
            stalled = 1'b0;
            if (bus.VALID_O) begin
                check("valid_implies_busy", bus.BUSY_O, 1);
                if (bus.READY_I) begin
                    beats_seen++;
                    check("beat_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        exp = exp_q.pop_front();
                        check("beat_data", bus.DATA_O, exp);
                    end
                end else begin
                    stalled = 1'b1;
                    held    = bus.DATA_O;
                end
            end
            if (bus.DONE_O) begin
                done_seen++;
                check("done_single_cycle", prev_done, 0);
            end
            prev_done = bus.DONE_O;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int n;
        rst         = 1'b1;
        bus.LOAD_I  = 1'b0;
        bus.START_I = 1'b0;
        bus.POLY_I  = '0;
        bus.SEED_I  = '0;
        bus.MODE_I  = 1'b0;
        bus.LEN_I   = '0;
        #12;
        check("rst_data",  bus.DATA_O,  0);
        check("rst_valid", bus.VALID_O, 0);
        check("rst_busy",  bus.BUSY_O,  0);
        check("rst_done",  bus.DONE_O,  0);
        check("rst_lock",  bus.LOCK_O,  0);
        tick();
        rst = 1'b0;
        tick();

        // Fibonacci full period, READY always high.
        do_load(4'b1100, 1, 1'b0);
        foreach (fib_seq[i]) exp_q.push_back(fib_seq[i]);
        start_run(15, 1'b0);
        wait_idle("fib15");
        check("fib15_back_to_seed", bus.DATA_O, 4'b0001);

        // Galois full period.
        do_load(4'b1100, 1, 1'b1);
        foreach (gal_seq[i]) exp_q.push_back(gal_seq[i]);
        start_run(15, 1'b0);
        wait_idle("gal15");

        // Fibonacci with random READY stalls.
        ready_rand = 1'b1;
        do_load(4'b1100, 1, 1'b0);
        foreach (fib_seq[i]) exp_q.push_back(fib_seq[i]);
        start_run(15, 1'b0);
        wait_idle("fib_stall");
        ready_rand = 1'b0;

        // START on the all-zero state locks and is refused.
        do_load(4'b1100, 0, 1'b0);
        b0 = beats_seen;
        start_run(5, 1'b1);
        wait_idle("lockup");
        check("lockup_no_beats", beats_seen, b0);
        do_load(4'b1100, 1, 1'b0);
        check("lock_cleared_by_load", bus.LOCK_O, m_lock);

        // LOAD and START together: LOAD wins, no run.
        bus.START_I = 1'b1;
        bus.LEN_I   = CNT_W'(4);
        do_load(4'b1100, 3, 1'b0);
        bus.START_I = 1'b0;
        @(negedge clk);
        check("load_start_busy", bus.BUSY_O, 0);
        check("load_start_seed", bus.DATA_O, 4'h3);
        tick();

        // LEN=0: DONE one cycle after START, no beats.
        do_load(4'b1100, 1, 1'b0);
        b0 = beats_seen;
        start_run(0, 1'b1);
        @(negedge clk);
        check("len0_done_pulse", bus.DONE_O, 1);
        check("len0_no_valid",   bus.VALID_O, 0);
        wait_idle("len0");
        check("len0_no_beats", beats_seen, b0);

        // Two LEN=3 runs continue the same sequence.
        for (int i = 0; i < 3; i++) exp_q.push_back(fib_seq[i]);
        start_run(3, 1'b0);
        wait_idle("cont_a");
        for (int i = 3; i < 6; i++) exp_q.push_back(fib_seq[i]);
        start_run(3, 1'b0);
        wait_idle("cont_b");

        // LOAD/START during RUN are ignored.
        ready_rand = 1'b1;
        do_load(4'b1100, 1, 1'b0);
        start_run(15, 1'b1);
        tick();
        bus.LOAD_I  = 1'b1;
        bus.START_I = 1'b1;
        bus.SEED_I  = 4'h7;
        bus.POLY_I  = 4'h3;
        bus.MODE_I  = 1'b1;
        bus.LEN_I   = CNT_W'(2);
        tick();
        bus.LOAD_I  = 1'b0;
        bus.START_I = 1'b0;
        wait_idle("ignore_in_run");

        // Randomised configurations.
        for (int r = 0; r < 8; r++) begin
            ready_rand = 1'($urandom_range(0, 1));
            do_load($urandom_range(1, 15), $urandom_range(1, 15), 1'($urandom_range(0, 1)));
            start_run($urandom_range(1, 40), 1'b1);
            wait_idle("rand");
        end

        // Reset in the middle of a run.
        ready_rand = 1'b0;
        do_load(4'b1100, 1, 1'b0);
        b0 = beats_seen;
        start_run(15, 1'b1);
        n = 0;
        while (beats_seen < b0 + 5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_run_reached_beat5", beats_seen >= b0 + 5, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_valid", bus.VALID_O, 0);
        check("midrst_busy",  bus.BUSY_O,  0);
        check("midrst_data",  bus.DATA_O,  0);
        check("midrst_done",  bus.DONE_O,  0);
        exp_q.delete();
        exp_done--;
        m_state = 0;
        m_poly  = 0;
        m_mode  = 1'b0;
        m_lock  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        wait_idle("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_lfsr_stream_gen

// File: doc/lfsr_stream_gen.md
# lfsr_stream_gen

Parametrised LFSR sequence generator: a run-time choice of Fibonacci or Galois structure, a programmable polynomial and seed, and a programmable run length. The generated states are streamed out over a valid/ready handshake. It replaces the fixed single-mode LFSR in the digital-design examples and feeds scramblers, BIST pattern sources and test-pattern buses. A control FSM sequences load, run and completion, and it flags an all-zero lock-up state.

## Interface
- W, 8, LFSR state width, 2..64
- CNT_W, 16, run-length counter width
- CLK_I  in  1  clock, all logic on rising edge
- RST_I  in  1  reset, asynchronous, active-high
- LOAD_I  in  1  capture POLY_I/SEED_I/MODE_I (IDLE only)
- POLY_I  in  W  tap mask, bit i = tap on state bit i
- SEED_I  in  W  initial state
- MODE_I  in  1  0 = Fibonacci, 1 = Galois
- LEN_I  in  CNT_W  number of output beats, sampled on START_I
- START_I  in  1  begin run (IDLE only)
- DATA_O  out  W  current LFSR state
- VALID_O  out  1  DATA_O valid
- READY_I  in  1  consumer accepts beat
- BUSY_O  out  1  FSM not IDLE
- DONE_O  out  1  one-cycle pulse after last beat accepted
- LOCK_O  out  1  sticky: START attempted with all-zero state

## Operation
- Reset: state/poly/mode/counter = 0, FSM = IDLE; DATA_O = 0, VALID_O = 0, BUSY_O = 0, DONE_O = 0, LOCK_O = 0.
- Fibonacci step: fb = ^(state & poly); next = {state[W-2:0], fb}.
- Galois step: next = {1'b0, state[W-1:1]} ^ ({W{state[0]}} & poly).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - LOAD_I loads poly, state ← SEED_I and mode, and clears LOCK_O.
  - START_I (without LOAD_I) and state == 0: LOCK_O ← 1; stay in IDLE.
  - START_I, state != 0 and LEN_I == 0: → DONE.
  - START_I, state != 0 and LEN_I > 0: counter ← LEN_I; → RUN.
  - LOAD_I and START_I in the same cycle: LOAD_I wins and START_I is ignored.
- RUN:
  - VALID_O = 1 and DATA_O = state.
  - On VALID_O && READY_I: state ← next, counter ← counter − 1.
  - If that beat is the last one (counter == 1): → DONE.
- DONE: DONE_O = 1 for exactly one cycle, then → IDLE.
- LOAD_I and START_I are ignored outside IDLE.
- Final state is retained after a run, so the next START continues the sequence without reloading.
- Counter arithmetic is unsigned CNT_W. The counter never wraps: the FSM leaves RUN when the count is exhausted.
- Poly and mode are frozen during RUN.

## Timing
- START_I accepted at edge n → VALID_O high from cycle n+1 with DATA_O = seed (first beat is the unadvanced state).
- Throughput: one beat per cycle while READY_I = 1.
- READY_I low stalls: DATA_O/VALID_O stay stable, and the state and counter hold.
- VALID_O never drops before its beat is accepted.
- DONE_O is high the cycle after the final handshake edge. BUSY_O is high in RUN and DONE.
- RST_I mid-run: all outputs go to reset values immediately (asynchronously). No DONE_O pulse; the loaded config is lost.
- LOCK_O is set at the edge that samples the bad START and holds until LOAD_I or reset.

## Structure
- Package lfsr_pkg:
  - typedef enum logic {LFSR_FIB, LFSR_GAL} lfsr_mode_e
  - typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} lfsr_state_e
- Sub-module lfsr_next_state: combinational, parameter W; inputs state, poly, mode; output next.
- Top lfsr_stream_gen: registers, FSM, counter and handshake.

## Test plan
- Fibonacci, W=4, POLY=4'b1100, SEED=4'b0001, LEN=15, READY=1 → beats 0001,0010,0100,1001,0011,0110,1101,1010,0101,1011,0111,1111,1110,1100,1000; DONE_O pulse; state back to 0001.
- Galois, same POLY/SEED, LEN=15 → 0001,1100,0110,0011,1101,1010,0101,1110,0111,1111,1011,1001,1000,0100,0010.
- Random READY_I stalls during the Fibonacci run → identical beat sequence; DATA_O stable whenever VALID_O && !READY_I.
- SEED=0, START → LOCK_O=1, BUSY_O=0, no VALID_O; then LOAD with SEED=1 → LOCK_O=0.
- LEN=0 → DONE_O one cycle after START, no beats. LEN=3 run followed by a second LEN=3 START → the second run continues the sequence (1001,0011,0110).
- RST_I asserted after beat 5 → VALID_O/BUSY_O/DATA_O drop to 0 asynchronously; no DONE_O. LOAD_I/START_I pulsed during RUN → ignored, sequence unchanged.
